// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - bootloader command core: byte protocol to multi-CS SPI flash and warmboot
module boot_ctrl #(
    parameter int CS_NUM         = 1,
    parameter int SCK_DIV        = 1,
    parameter int TIMEOUT_CYCLES = 16000000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [7:0]        out_data_i,
    input  logic              out_valid_i,
    output logic              out_ready_o,
    output logic [7:0]        in_data_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    output logic              sck_o,
    output logic [CS_NUM-1:0] csn_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [1:0]        boot_sel_o,
    output logic              boot_o,
    output logic              timeout_o
);

    localparam int              DW       = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(SCK_DIV - 1);
    localparam logic [4:0]      CS_LIM   = 5'(CS_NUM);
    localparam logic [31:0]     TMO      = 32'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_BOOT_IDX, S_BOOTING, S_HDR, S_CS_SETUP,
        S_WR_WAIT, S_WR_SHIFT, S_RD_SHIFT, S_RD_PUSH, S_CS_HOLD
    } state_t;

    state_t            state;
    logic [1:0]        hdr_cnt;
    logic [15:0]       wlen;
    logic [15:0]       rlen;
    logic [3:0]        cs_idx;
    logic [DW-1:0]     div_cnt;
    logic [2:0]        bit_cnt;
    logic [6:0]        tx_sr;
    logic [7:0]        rx_sr;
    logic [31:0]       tcnt;
    logic [CS_NUM-1:0] cs_sel;
    logic              accept;
    logic              tmo_run;
    logic              tmo_hit;

    assign out_ready_o = rstn_i && (state == S_IDLE || state == S_BOOT_IDX ||
                                    state == S_HDR  || state == S_WR_WAIT);
    assign accept  = out_valid_i && out_ready_o;
    assign tmo_run = (TMO != 32'd0) && !out_valid_i &&
                     (state == S_BOOT_IDX || state == S_HDR || state == S_WR_WAIT);
    assign tmo_hit = tmo_run && (tcnt + 32'd1 == TMO);

    always_comb begin
        cs_sel = '0;
        for (int i = 0; i < CS_NUM; i++) begin
            cs_sel[i] = (cs_idx == 4'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            hdr_cnt    <= '0;
            wlen       <= '0;
            rlen       <= '0;
            cs_idx     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            tcnt       <= '0;
            in_data_o  <= '0;
            in_valid_o <= 1'b0;
            sck_o      <= 1'b0;
            csn_o      <= '1;
            mosi_o     <= 1'b0;
            boot_sel_o <= '0;
            boot_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            tcnt      <= tmo_run ? tcnt + 32'd1 : 32'd0;
            if (tmo_hit) begin
                // stalled host: drop the partial command and release the bus
                state     <= S_IDLE;
                timeout_o <= 1'b1;
                csn_o     <= '1;
                sck_o     <= 1'b0;
                mosi_o    <= 1'b0;
                hdr_cnt   <= '0;
                wlen      <= '0;
                rlen      <= '0;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        cs_idx  <= ({1'b0, out_data_i[3:0]} < CS_LIM) ? out_data_i[3:0] : 4'd0;
                        hdr_cnt <= '0;
                        if (out_data_i[7:4] == 4'h0) state <= S_BOOT_IDX;
                        else if (out_data_i[7:4] == 4'h1) state <= S_HDR;
                    end
                    S_BOOT_IDX: if (accept) begin
                        boot_sel_o <= out_data_i[1:0];
                        state      <= S_BOOTING;
                    end
                    S_BOOTING: boot_o <= 1'b1;
                    S_HDR: if (accept) begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        case (hdr_cnt)
                            2'd0: wlen[7:0]  <= out_data_i;
                            2'd1: wlen[15:8] <= out_data_i;
                            2'd2: rlen[7:0]  <= out_data_i;
                            2'd3: begin
                                rlen[15:8] <= out_data_i;
                                if (wlen == 16'd0 && rlen[7:0] == 8'd0 && out_data_i == 8'd0) begin
                                    state <= S_IDLE;
                                end else begin
                                    state   <= S_CS_SETUP;
                                    csn_o   <= ~cs_sel;
                                    div_cnt <= '0;
                                    bit_cnt <= '0;
                                end
                            end
                        endcase
                    end
                    S_CS_SETUP: begin
                        if (div_cnt != DIV_LAST) begin
                            div_cnt <= div_cnt + DW'(1);
                        end else begin
                            div_cnt <= '0;
                            mosi_o  <= 1'b0;
                            state   <= (wlen != 16'd0) ? S_WR_WAIT : S_RD_SHIFT;
                        end
                    end
                    S_WR_WAIT: if (accept) begin
                        tx_sr   <= out_data_i[6:0];
                        mosi_o  <= out_data_i[7];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_WR_SHIFT;
                    end
                    S_WR_SHIFT, S_RD_SHIFT: begin
                        if (div_cnt != DIV_LAST) begin
                            div_cnt <= div_cnt + DW'(1);
                        end else if (!sck_o) begin
                            div_cnt <= '0;
                            sck_o   <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], miso_i};
                        end else begin
                            div_cnt <= '0;
                            sck_o   <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sr   <= {tx_sr[5:0], 1'b0};
                            mosi_o  <= (state == S_WR_SHIFT) ? tx_sr[6] : 1'b0;
                            if (bit_cnt == 3'd7) begin
                                mosi_o <= 1'b0;
                                if (state == S_RD_SHIFT) begin
                                    in_data_o  <= rx_sr;
                                    in_valid_o <= 1'b1;
                                    state      <= S_RD_PUSH;
                                end else if (wlen != 16'd1) begin
                                    wlen  <= wlen - 16'd1;
                                    state <= S_WR_WAIT;
                                end else begin
                                    wlen  <= '0;
                                    state <= (rlen != 16'd0) ? S_RD_SHIFT : S_CS_HOLD;
                                end
                            end
                        end
                    end
                    S_RD_PUSH: if (in_ready_i) begin
                        in_valid_o <= 1'b0;
                        rlen       <= rlen - 16'd1;
                        state      <= (rlen != 16'd1) ? S_RD_SHIFT : S_CS_HOLD;
                    end
                    S_CS_HOLD: begin
                        if (div_cnt != DIV_LAST) begin
                            div_cnt <= div_cnt + DW'(1);
                        end else begin
                            div_cnt <= '0;
                            csn_o   <= '1;
                            state   <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - randomized self-checking bench for boot_ctrl against a byte-level SPI model
module tb_boot_ctrl;

    localparam int CS_NUM  = 2;
    localparam int SCK_DIV = 2;
    localparam int TMO     = 100;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [7:0]        out_data = 8'd0;
    logic              out_valid = 1'b0;
    logic              out_ready;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready = 1'b1;
    logic              sck;
    logic [CS_NUM-1:0] csn;
    logic              mosi;
    logic              miso = 1'b0;
    logic [1:0]        boot_sel;
    logic              boot;
    logic              timeout;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;

    boot_ctrl #(.CS_NUM(CS_NUM), .SCK_DIV(SCK_DIV), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(out_ready),
        .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready),
        .sck_o(sck), .csn_o(csn), .mosi_o(mosi), .miso_i(miso),
        .boot_sel_o(boot_sel), .boot_o(boot), .timeout_o(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SPI slave / host-side observer state
    logic [7:0]  wq[$];
    logic [7:0]  rq[$];
    bit          miso_bits[$];
    bit          mosi_q[$];
    int          rise_t[$];
    logic [7:0]  rx_q[$];
    logic        prev_sck = 1'b0;
    int          rise_cnt = 0;
    int          last_rise = 0;
    int          hi_err = 0;
    int          multi_err = 0;
    int          tmo_cnt = 0;
    int          stall_left = 0;
    int          bp_err = 0;
    bit          rand_rdy = 1'b0;
    logic [7:0]  exp_stall_data = 8'd0;
    logic [1:0]  csn_low_acc = 2'b00;

    always @(negedge clk) begin
        if (sck && !prev_sck) begin
            rise_cnt++;
            mosi_q.push_back(mosi);
            rise_t.push_back(cyc);
            last_rise = cyc;
        end
        if (!sck && prev_sck && (cyc - last_rise != SCK_DIV)) hi_err++;
        prev_sck = sck;
        miso = (rise_cnt < miso_bits.size()) ? miso_bits[rise_cnt] : 1'b0;
        csn_low_acc |= ~csn;
        if ($countones(~csn) > 1) multi_err++;
        if (timeout) tmo_cnt++;
        if (in_valid && stall_left > 0) begin
            in_ready = 1'b0;
            stall_left--;
            if (in_data !== exp_stall_data || sck !== 1'b0) bp_err++;
        end else begin
            in_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (in_valid && in_ready && rstn) rx_q.push_back(in_data);
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        out_data  = b;
        out_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (out_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        out_valid = 1'b0;
        checks++;
        if (!ok) $display("FAIL send_byte: byte %0h accepted=%0d required=1", b, ok);
        else passes++;
    endtask

    task automatic apply_reset();
        out_valid = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Drives one XFER and checks it against the byte-level model in wq/rq
    task automatic run_xfer(input logic [3:0] idx, input int stall, input bit rr, input string tag);
        int nw, nr, eff, bad_iv;
        bit done;
        logic [1:0] exp_low;
        logic [7:0] got, expb;
        nw = wq.size();
        nr = rq.size();
        eff = (idx < CS_NUM) ? int'(idx) : 0;
        exp_low = (nw + nr == 0) ? 2'b00 : (2'b01 << eff);
        mosi_q.delete(); rise_t.delete(); rx_q.delete(); miso_bits.delete();
        rise_cnt = 0; hi_err = 0; multi_err = 0; tmo_cnt = 0; bp_err = 0;
        csn_low_acc = 2'b00; stall_left = stall; rand_rdy = rr;
        exp_stall_data = (nr > 0) ? rq[0] : 8'd0;
        for (int i = 0; i < 8 * nw; i++) miso_bits.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < nr; i++)
            for (int b = 7; b >= 0; b--) miso_bits.push_back(rq[i][b]);

        send_byte({4'h1, idx});
        send_byte(8'(nw)); send_byte(8'(nw >> 8));
        send_byte(8'(nr)); send_byte(8'(nr >> 8));
        if (nw + nr == 0) begin
            checks++;
            if (out_ready !== 1'b1) $display("FAIL %s zero_len_ready: got %0b expected 1", tag, out_ready);
            else passes++;
        end
        for (int i = 0; i < nw; i++) send_byte(wq[i]);

        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            #1;
            done = (rx_q.size() == nr) && (csn === 2'b11) && out_ready;
        end
        @(negedge clk);
        #1;
        checks++;
        if (!done) $display("FAIL %s completion: done=%0b required=1 rx=%0d/%0d", tag, done, rx_q.size(), nr);
        else passes++;
        checks++;
        if (rise_cnt !== 8 * (nw + nr)) $display("FAIL %s sck_rises: got %0d expected %0d", tag, rise_cnt, 8 * (nw + nr));
        else passes++;
        for (int by = 0; by < nw + nr; by++) begin
            got = 8'd0;
            for (int j = 0; j < 8; j++)
                got = {got[6:0], (8 * by + j < mosi_q.size()) ? mosi_q[8 * by + j] : 1'b0};
            expb = (by < nw) ? wq[by] : 8'h00;
            checks++;
            if (got !== expb) $display("FAIL %s mosi_byte%0d: got %0h expected %0h", tag, by, got, expb);
            else passes++;
        end
        for (int i = 0; i < nr; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== rq[i]) $display("FAIL %s rd_byte%0d: got %0h expected %0h", tag, i, got, rq[i]);
            else passes++;
        end
        bad_iv = 0;
        for (int k = 1; k < rise_t.size(); k++)
            if (k % 8 != 0 && rise_t[k] - rise_t[k-1] != 2 * SCK_DIV) bad_iv++;
        checks++;
        if (bad_iv + hi_err !== 0) $display("FAIL %s bit_timing: bad_periods=%0d bad_high=%0d expected 0", tag, bad_iv, hi_err);
        else passes++;
        checks++;
        if (csn_low_acc !== exp_low || multi_err !== 0)
            $display("FAIL %s cs_activity: low_bits=%b expected %b multi=%0d", tag, csn_low_acc, exp_low, multi_err);
        else passes++;
        checks++;
        if (tmo_cnt !== 0) $display("FAIL %s no_timeout: pulses=%0d expected 0", tag, tmo_cnt);
        else passes++;
        if (stall > 0) begin
            checks++;
            if (bp_err !== 0 || stall_left !== 0)
                $display("FAIL %s backpressure: errs=%0d stall_left=%0d expected 0/0", tag, bp_err, stall_left);
            else passes++;
        end
        rand_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        checks++;
        if ({out_ready, in_valid, in_data, sck, csn, mosi, boot_sel, boot, timeout} !== 18'b0_0_00000000_0_11_0_00_0_0)
            $display("FAIL reset_state: got %b expected %b",
                     {out_ready, in_valid, in_data, sck, csn, mosi, boot_sel, boot, timeout}, 18'b0_0_00000000_0_11_0_00_0_0);
        else passes++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (out_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b expected 1", out_ready);
        else passes++;
    endtask

    task automatic test_xfer_basic();
        wq = '{8'h9F};
        rq = '{8'hEF, 8'h40};
        run_xfer(4'd1, 0, 1'b0, "xfer_basic");
    endtask

    task automatic test_backpressure();
        wq = '{8'h9F};
        rq = '{8'hEF, 8'h40};
        run_xfer(4'd1, 50, 1'b0, "backpressure");
    endtask

    task automatic test_zero_len();
        wq.delete();
        rq.delete();
        run_xfer(4'd0, 0, 1'b0, "zero_len");
    endtask

    task automatic test_random();
        logic [3:0] idx;
        int nw, nr;
        for (int t = 0; t < 6; t++) begin
            idx = 4'($urandom_range(0, 15));
            nw = $urandom_range(0, 3);
            nr = $urandom_range(0, 3);
            wq.delete();
            rq.delete();
            for (int i = 0; i < nw; i++) wq.push_back(8'($urandom));
            for (int i = 0; i < nr; i++) rq.push_back(8'($urandom));
            run_xfer(idx, 0, 1'b1, $sformatf("random%0d", t));
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h10);
        send_byte(8'd1); send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
        send_byte(8'hA5);
        repeat (3) @(negedge clk);
        checks++;
        if (csn !== 2'b10) $display("FAIL mid_cs_active: got %b expected 10", csn);
        else passes++;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({csn, sck, out_ready} !== 4'b11_0_0)
            $display("FAIL mid_reset_async: got %b expected 1100", {csn, sck, out_ready});
        else passes++;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (out_ready !== 1'b1) $display("FAIL mid_reset_release: got %0b expected 1", out_ready);
        else passes++;
    endtask

    task automatic test_timeout();
        int c0;
        tmo_cnt = 0;
        send_byte(8'h10);
        send_byte(8'h05);
        send_byte(8'h00);
        c0 = acc_cyc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (timeout) break;
        end
        checks++;
        if (cyc - c0 !== TMO) $display("FAIL timeout_latency: got %0d expected %0d", cyc - c0, TMO);
        else passes++;
        @(negedge clk);
        checks++;
        if ({timeout, csn, sck, out_ready} !== 5'b0_11_0_1)
            $display("FAIL timeout_after: got %b expected 01101", {timeout, csn, sck, out_ready});
        else passes++;
        send_byte(8'h00);
        send_byte(8'h03);
        checks++;
        if ({boot_sel, boot} !== 3'b11_0) $display("FAIL tmo_boot_sel: got %b expected 110", {boot_sel, boot});
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (boot !== 1'b1) $display("FAIL tmo_boot: got %0b expected 1", boot);
        else passes++;
    endtask

    task automatic test_boot();
        int rdy_seen;
        send_byte(8'h50);
        checks++;
        if ({out_ready, boot_sel, boot} !== 4'b1_00_0)
            $display("FAIL unknown_opcode: got %b expected 1000", {out_ready, boot_sel, boot});
        else passes++;
        send_byte(8'h00);
        send_byte(8'h02);
        checks++;
        if ({boot_sel, boot} !== 3'b10_0) $display("FAIL boot_sel_lead: got %b expected 100", {boot_sel, boot});
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (boot !== 1'b1) $display("FAIL boot_pulse: got %0b expected 1", boot);
        else passes++;
        rdy_seen = 0;
        out_data = 8'h10;
        out_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_ready) rdy_seen++;
        end
        out_valid = 1'b0;
        checks++;
        if ({boot, boot_sel} !== 3'b1_10 || rdy_seen !== 0)
            $display("FAIL boot_terminal: boot/sel=%b expected 110 ready_cycles=%0d expected 0", {boot, boot_sel}, rdy_seen);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_xfer_basic();
        test_backpressure();
        test_zero_len();
        test_random();
        test_reset_mid();
        test_timeout();
        apply_reset();
        test_boot();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
